// File: rtl/atm_pkg.sv
// Shared types for the ATM: authorizer state encoding, controller state, pulse bundle.
// The BCD validity helper is also used by the PIN checker.
package atm_pkg;

  localparam int PIN_W = 16;
  localparam int AMT_W = 16;
  localparam int TRY_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PIN  = 3'd1,
    WAIT_AMT  = 3'd2,
    WAIT_DISP = 3'd3,
    LOCKED    = 3'd4
  } auth_state_t;

  typedef enum logic [1:0] {
    CTRL_IDLE     = 2'd0,
    CTRL_AUTH     = 2'd1,
    CTRL_DISPENSE = 2'd2,
    CTRL_EJECT    = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic pin_correct;
    logic pin_error;
    logic balance_ok;
    logic balance_err;
  } auth_pulses_t;

  function automatic logic bcd_valid(input logic [PIN_W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < PIN_W / 4; i++) begin
      if (value[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/atm_pin_check.sv
// Combinational PIN check: entry must be valid BCD on every digit and equal the stored PIN.
module atm_pin_check
  import atm_pkg::*;
(
  input  logic [PIN_W-1:0] pin_in,
  input  logic [PIN_W-1:0] stored_pin,
  output logic             match
);

  always_comb begin
    match = bcd_valid(pin_in) && (pin_in == stored_pin);
  end

endmodule

// File: rtl/atm_authorizer.sv
// ATM account authorizer: PIN verification with persistent lockout, withdrawal
// authorization against the balance, and debit once the cash has been dispensed.
module atm_authorizer
  import atm_pkg::*;
#(
  parameter logic [15:0] STORED_PIN   = 16'h1234,
  parameter logic [15:0] INIT_BALANCE = 16'd1000,
  parameter int          MAX_TRIES    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_inserted,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin_in,
  input  logic             amt_valid,
  input  logic [AMT_W-1:0] amt_in,
  input  logic             dispense_ack,
  output logic             pin_correct,
  output logic             pin_error,
  output logic             balance_ok,
  output logic             balance_err,
  output logic             locked,
  output logic [AMT_W-1:0] balance
);

  localparam logic [TRY_W-1:0] MAX_TRIES_L = TRY_W'(MAX_TRIES);

  auth_state_t      state, state_next;
  logic [TRY_W-1:0] try_cnt, try_cnt_next, try_inc;
  logic [AMT_W-1:0] bal_q, bal_next;
  logic [AMT_W-1:0] amt_q, amt_next;
  auth_pulses_t     pulses_q, pulses_next;
  logic             pin_match;

  atm_pin_check u_pin_check (
    .pin_in     (pin_in),
    .stored_pin (STORED_PIN),
    .match      (pin_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      try_cnt  <= '0;
      bal_q    <= INIT_BALANCE;
      amt_q    <= '0;
      pulses_q <= '0;
    end else begin
      state    <= state_next;
      try_cnt  <= try_cnt_next;
      bal_q    <= bal_next;
      amt_q    <= amt_next;
      pulses_q <= pulses_next;
    end
  end

  // Card removal beats any strobe in the active states; pulses are registered one cycle later.
  always_comb begin
    state_next   = state;
    try_cnt_next = try_cnt;
    bal_next     = bal_q;
    amt_next     = amt_q;
    pulses_next  = '0;
    try_inc      = try_cnt + TRY_W'(1);

    case (state)
      IDLE: begin
        if (card_inserted) state_next = WAIT_PIN;
      end

      WAIT_PIN: begin
        if (!card_inserted) begin
          state_next = IDLE;
        end else if (pin_valid) begin
          if (pin_match) begin
            pulses_next.pin_correct = 1'b1;
            try_cnt_next            = '0;
            state_next              = WAIT_AMT;
          end else begin
            pulses_next.pin_error = 1'b1;
            try_cnt_next          = try_inc;
            if (try_inc == MAX_TRIES_L) state_next = LOCKED;
          end
        end
      end

      WAIT_AMT: begin
        if (!card_inserted) begin
          state_next = IDLE;
        end else if (amt_valid) begin
          if ((amt_in != '0) && (amt_in <= bal_q)) begin
            amt_next               = amt_in;
            pulses_next.balance_ok = 1'b1;
            state_next             = WAIT_DISP;
          end else begin
            pulses_next.balance_err = 1'b1;
            state_next              = IDLE;
          end
        end
      end

      WAIT_DISP: begin
        if (!card_inserted) begin
          state_next = IDLE;
        end else if (dispense_ack) begin
          bal_next   = bal_q - amt_q;
          state_next = IDLE;
        end
      end

      LOCKED: begin
        state_next = LOCKED;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pin_correct = pulses_q.pin_correct;
  assign pin_error   = pulses_q.pin_error;
  assign balance_ok  = pulses_q.balance_ok;
  assign balance_err = pulses_q.balance_err;
  assign locked      = (state == LOCKED);
  assign balance     = bal_q;

endmodule

// File: tb/tb_atm_authorizer.sv
// Directed bench for atm_authorizer: a vector table for single-session behaviour plus
// hand-written multi-cycle sequences for lockout, overdraw and mid-transaction reset.
module tb_atm_authorizer;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] PC   = 4'b1000;
  localparam logic [3:0] PE   = 4'b0100;
  localparam logic [3:0] BO   = 4'b0010;
  localparam logic [3:0] BE   = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        card_inserted;
  logic        pin_valid;
  logic [15:0] pin_in;
  logic        amt_valid;
  logic [15:0] amt_in;
  logic        dispense_ack;
  logic        pin_correct;
  logic        pin_error;
  logic        balance_ok;
  logic        balance_err;
  logic        locked;
  logic [15:0] balance;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic        card;
    logic        pv;
    logic [15:0] pin;
    logic        av;
    logic [15:0] amt;
    logic        ack;
    logic [3:0]  exp_pulses;
    logic        exp_locked;
    logic [15:0] exp_balance;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  atm_authorizer dut (
    .clk           (clk),
    .reset         (reset),
    .card_inserted (card_inserted),
    .pin_valid     (pin_valid),
    .pin_in        (pin_in),
    .amt_valid     (amt_valid),
    .amt_in        (amt_in),
    .dispense_ack  (dispense_ack),
    .pin_correct   (pin_correct),
    .pin_error     (pin_error),
    .balance_ok    (balance_ok),
    .balance_err   (balance_err),
    .locked        (locked),
    .balance       (balance)
  );

  task automatic applyStimulus(input logic rst, input logic card, input logic pv,
                               input logic [15:0] pin, input logic av,
                               input logic [15:0] amt, input logic ack);
    @(negedge clk);
    reset         = rst;
    card_inserted = card;
    pin_valid     = pv;
    pin_in        = pin;
    amt_valid     = av;
    amt_in        = amt;
    dispense_ack  = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] exp_pulses,
                             input logic exp_locked, input logic [15:0] exp_balance);
    logic [3:0] act_pulses;
    act_pulses = {pin_correct, pin_error, balance_ok, balance_err};
    tests_run++;
    if (act_pulses !== exp_pulses || locked !== exp_locked || balance !== exp_balance) begin
      tests_failed++;
      $display("[TB] FAIL %s: got pulses=%b locked=%b balance=%0d, expected pulses=%b locked=%b balance=%0d",
               name, act_pulses, locked, balance, exp_pulses, exp_locked, exp_balance);
    end
  endtask

  task automatic runStep(input string name, input logic card, input logic pv,
                         input logic [15:0] pin, input logic av, input logic [15:0] amt,
                         input logic ack, input logic [3:0] exp_pulses,
                         input logic exp_locked, input logic [15:0] exp_balance);
    applyStimulus(1'b0, card, pv, pin, av, amt, ack);
    checkOutput(name, exp_pulses, exp_locked, exp_balance);
  endtask

  task automatic resetWith(input string name, input logic card, input logic av,
                           input logic [15:0] amt);
    applyStimulus(1'b1, card, 1'b0, 16'h0, av, amt, 1'b0);
    checkOutput(name, NONE, 1'b0, 16'd1000);
  endtask

  initial begin
    logic [2:0] tries_seen;

    reset = 1'b1; card_inserted = 1'b0; pin_valid = 1'b0; pin_in = '0;
    amt_valid = 1'b0; amt_in = '0; dispense_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_state", NONE, 1'b0, 16'd1000);

    // name, card, pv, pin, av, amt, ack, pulses, locked, balance
    vecs.push_back('{"card_in",        1, 0, 16'h0000, 0, 16'd0,   0, NONE, 0, 16'd1000});
    vecs.push_back('{"pin_ok",         1, 1, 16'h1234, 0, 16'd0,   0, PC,   0, 16'd1000});
    vecs.push_back('{"amt_300",        1, 0, 16'h0000, 1, 16'd300, 0, BO,   0, 16'd1000});
    vecs.push_back('{"ack_debit",      1, 0, 16'h0000, 0, 16'd0,   1, NONE, 0, 16'd700});
    vecs.push_back('{"card_out",       0, 0, 16'h0000, 0, 16'd0,   0, NONE, 0, 16'd700});
    vecs.push_back('{"card_in2",       1, 0, 16'h0000, 0, 16'd0,   0, NONE, 0, 16'd700});
    vecs.push_back('{"pin_bad_bcd",    1, 1, 16'h12A4, 0, 16'd0,   0, PE,   0, 16'd700});
    vecs.push_back('{"pin_ok2",        1, 1, 16'h1234, 0, 16'd0,   0, PC,   0, 16'd700});
    vecs.push_back('{"amt_zero",       1, 0, 16'h0000, 1, 16'd0,   0, BE,   0, 16'd700});
    vecs.push_back('{"reenter_pin",    1, 0, 16'h0000, 0, 16'd0,   0, NONE, 0, 16'd700});
    vecs.push_back('{"pin_ok3",        1, 1, 16'h1234, 0, 16'd0,   0, PC,   0, 16'd700});
    vecs.push_back('{"amt_over",       1, 0, 16'h0000, 1, 16'd701, 0, BE,   0, 16'd700});
    vecs.push_back('{"reenter_pin2",   1, 0, 16'h0000, 0, 16'd0,   0, NONE, 0, 16'd700});
    vecs.push_back('{"pin_ok4",        1, 1, 16'h1234, 0, 16'd0,   0, PC,   0, 16'd700});
    vecs.push_back('{"amt_exact",      1, 0, 16'h0000, 1, 16'd700, 0, BO,   0, 16'd700});
    vecs.push_back('{"card_out_ack",   0, 0, 16'h0000, 0, 16'd0,   1, NONE, 0, 16'd700});
    vecs.push_back('{"idle_ack",       0, 0, 16'h0000, 0, 16'd0,   1, NONE, 0, 16'd700});
    vecs.push_back('{"idle_pin",       1, 1, 16'h1234, 0, 16'd0,   0, NONE, 0, 16'd700});
    vecs.push_back('{"waitpin_amt",    1, 0, 16'h0000, 1, 16'd100, 0, NONE, 0, 16'd700});
    vecs.push_back('{"card_out_pin",   0, 1, 16'h1234, 0, 16'd0,   0, NONE, 0, 16'd700});

    for (int i = 0; i < vecs.size(); i++) begin
      runStep(vecs[i].name, vecs[i].card, vecs[i].pv, vecs[i].pin, vecs[i].av,
              vecs[i].amt, vecs[i].ack, vecs[i].exp_pulses, vecs[i].exp_locked,
              vecs[i].exp_balance);
    end

    // Overdraw from a fresh balance, then withdraw everything in a new session.
    resetWith("od_reset", 1'b0, 1'b0, 16'd0);
    runStep("od_card",   1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("od_pin",    1, 1, 16'h1234, 0, 16'd0,    0, PC,   0, 16'd1000);
    runStep("od_1001",   1, 0, 16'h0000, 1, 16'd1001, 0, BE,   0, 16'd1000);
    runStep("od_card2",  1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("od_pin2",   1, 1, 16'h1234, 0, 16'd0,    0, PC,   0, 16'd1000);
    runStep("od_1000",   1, 0, 16'h0000, 1, 16'd1000, 0, BO,   0, 16'd1000);
    runStep("od_ack",    1, 0, 16'h0000, 0, 16'd0,    1, NONE, 0, 16'd0);
    runStep("od_out",    0, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd0);

    // Reset while waiting for an amount abandons the session and restores the balance.
    runStep("rm_card",   1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd0);
    runStep("rm_pin",    1, 1, 16'h1234, 0, 16'd0,    0, PC,   0, 16'd0);
    resetWith("rm_reset", 1'b1, 1'b1, 16'd100);
    runStep("rm_idle",   1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("rm_no_amt", 1, 0, 16'h0000, 1, 16'd100,  0, NONE, 0, 16'd1000);
    runStep("rm_pin2",   1, 1, 16'h1234, 0, 16'd0,    0, PC,   0, 16'd1000);

    // Three wrong PINs in one session lock the account; nothing after that is honoured.
    resetWith("lk_reset", 1'b0, 1'b0, 16'd0);
    runStep("lk_card",   1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("lk_bad1",   1, 1, 16'h1111, 0, 16'd0,    0, PE,   0, 16'd1000);
    runStep("lk_bad2",   1, 1, 16'h1111, 0, 16'd0,    0, PE,   0, 16'd1000);
    runStep("lk_bad3",   1, 1, 16'h1111, 0, 16'd0,    0, PE,   1, 16'd1000);
    runStep("lk_good",   1, 1, 16'h1234, 0, 16'd0,    0, NONE, 1, 16'd1000);
    runStep("lk_out",    0, 0, 16'h0000, 0, 16'd0,    0, NONE, 1, 16'd1000);
    runStep("lk_again",  1, 1, 16'h1234, 0, 16'd0,    0, NONE, 1, 16'd1000);

    // Wrong PINs accumulate across separate card sessions.
    resetWith("ps_reset", 1'b0, 1'b0, 16'd0);
    runStep("ps_card1",  1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("ps_bad1",   1, 1, 16'h1111, 0, 16'd0,    0, PE,   0, 16'd1000);
    runStep("ps_out1",   0, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("ps_card2",  1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("ps_bad2",   1, 1, 16'h9999, 0, 16'd0,    0, PE,   0, 16'd1000);
    runStep("ps_out2",   0, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("ps_card3",  1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("ps_bad3",   1, 1, 16'h1235, 0, 16'd0,    0, PE,   1, 16'd1000);

    // An invalid BCD entry counts as exactly one failed try.
    resetWith("bcd_reset", 1'b0, 1'b0, 16'd0);
    runStep("bcd_card",  1, 0, 16'h0000, 0, 16'd0,    0, NONE, 0, 16'd1000);
    runStep("bcd_bad",   1, 1, 16'h12A4, 0, 16'd0,    0, PE,   0, 16'd1000);
    tries_seen = dut.try_cnt;
    tests_run++;
    if (tries_seen !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL bcd_tries: got try count=%0d, expected 1", tries_seen);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/atm_authorizer.md
ATM_AUTHORIZER -- requirements
Module: atm_authorizer

Interface
REQ-001 Parameter STORED_PIN, default 16'h1234, 4-digit BCD account PIN.
REQ-002 Parameter INIT_BALANCE, default 16'd1000, account balance loaded at reset.
REQ-003 Parameter MAX_TRIES, default 3, wrong-PIN attempts before lockout; range 1-7.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 card_inserted  input  1  level, high while a card is in the ATM.
REQ-007 pin_valid  input  1  one-cycle strobe qualifying pin_in.
REQ-008 pin_in  input  16  entered PIN, 4 BCD digits.
REQ-009 amt_valid  input  1  one-cycle strobe qualifying amt_in.
REQ-010 amt_in  input  16  requested withdrawal amount, unsigned.
REQ-011 dispense_ack  input  1  one-cycle strobe from the ATM controller's dispense_cash.
REQ-012 pin_correct  output  1  registered one-cycle pulse, PIN accepted.
REQ-013 pin_error  output  1  registered one-cycle pulse, PIN rejected.
REQ-014 balance_ok  output  1  registered one-cycle pulse, withdrawal authorized.
REQ-015 balance_err  output  1  registered one-cycle pulse, withdrawal refused.
REQ-016 locked  output  1  level, account locked.
REQ-017 balance  output  16  current account balance.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_PIN, WAIT_AMT, WAIT_DISP, LOCKED.
REQ-019 IDLE: card_inserted=1 -> WAIT_PIN; otherwise hold.
REQ-020 WAIT_PIN, pin_valid=1, pin_in==STORED_PIN: pin_correct pulses next cycle, try counter clears, -> WAIT_AMT.
REQ-021 WAIT_PIN, pin_valid=1, mismatch, or any nibble >9: pin_error pulses next cycle, try counter increments; if the new count equals MAX_TRIES -> LOCKED, else stay in WAIT_PIN.
REQ-022 Try counter SHALL persist across card sessions; it clears only on a correct PIN or on reset.
REQ-023 WAIT_AMT, amt_valid=1, 0<amt_in<=balance: latch amt_in, pulse balance_ok next cycle, -> WAIT_DISP.
REQ-024 WAIT_AMT, amt_valid=1, amt_in==0 or amt_in>balance: pulse balance_err next cycle, -> IDLE, balance unchanged.
REQ-025 WAIT_DISP, dispense_ack=1: balance <= balance - latched amount (never underflows, per REQ-023), -> IDLE.
REQ-026 In WAIT_PIN, WAIT_AMT and WAIT_DISP, card_inserted=0 SHALL take priority over strobes in the same cycle: -> IDLE, no pulse, no debit.
REQ-027 LOCKED: locked=1; all inputs ignored; exit only via reset.
REQ-028 Strobes arriving in states that do not expect them SHALL be ignored.
REQ-029 At most one of pin_correct, pin_error, balance_ok and balance_err SHALL be high in any cycle.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE, try counter=0, balance=INIT_BALANCE, all pulse outputs=0, locked=0, latched amount=0.
REQ-031 Reset mid-transaction SHALL abandon it with no debit and no pulse in the following cycle.

Structure
REQ-032 The state enum, with a 3-bit encoding, SHALL live in the shared package atm_pkg, alongside the ATM controller's types.
REQ-033 The BCD-validity and PIN-compare check SHALL be a sub-module, atm_pin_check: combinational, pin_in and STORED_PIN in, match out.
REQ-034 Implementation SHALL use one always_ff for state and registers and one always_comb for next-state logic.

Verification
REQ-035 Happy path: card, pin 16'h1234, amt 300, dispense_ack -> pin_correct, balance_ok, balance=700.
REQ-036 Lockout: three pins 16'h1111 -> three pin_error pulses, locked=1 after the third; a further pin 16'h1234 is ignored.
REQ-037 Overdraw: balance 1000, amt 1001 -> balance_err, IDLE, balance=1000; amt 1000 in a new session -> balance_ok, balance=0 after ack.
REQ-038 Invalid BCD: pin 16'h12A4 -> pin_error, try counter=1.
REQ-039 Card removed in WAIT_DISP in the same cycle as dispense_ack -> IDLE, balance unchanged.
REQ-040 Reset asserted in WAIT_AMT -> IDLE next cycle, balance=INIT_BALANCE, locked=0, no pulses.
